// File: rtl/mult_share_arbiter_if.sv
// Requester, response and multiplier-core signals of mult_share_arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface mult_share_arbiter_if #(
  parameter int OP_W  = 16,
  parameter int RES_W = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OP_W-1:0]  req0_a;
  logic [OP_W-1:0]  req0_b;
  logic             rsp0_valid;
  logic             rsp0_ready;

  logic             req1_valid;
  logic             req1_ready;
  logic [OP_W-1:0]  req1_a;
  logic [OP_W-1:0]  req1_b;
  logic             rsp1_valid;
  logic             rsp1_ready;

  logic [RES_W-1:0] rsp_result;
  logic             rsp_err;

  logic             mul_init;
  logic [OP_W-1:0]  mul_a;
  logic [OP_W-1:0]  mul_b;
  logic [RES_W-1:0] mul_result;
  logic             mul_done;

  logic             busy;
  logic             grant_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_a, req1_b, rsp1_ready,
    input  mul_result, mul_done,
    output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    output rsp_result, rsp_err, mul_init, mul_a, mul_b, busy, grant_id
  );

  modport master (
    output req0_valid, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_a, req1_b, rsp1_ready,
    output mul_result, mul_done,
    input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    input  rsp_result, rsp_err, mul_init, mul_a, mul_b, busy, grant_id
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one shift-add multiplier core between two requesters.
// Optional WAIT timeout with error response: define MULT_ARB_TIMEOUT_EN.
module mult_share_arbiter #(
  parameter int OP_W        = 16,
  parameter int RES_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_share_arbiter_if.slave  bus
);

  if (RES_W != 2 * OP_W || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("mult_share_arbiter: RES_W must be 2*OP_W and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_rr_ptr;
  logic             r_grant_id;
  logic             r_done_armed;
  logic [OP_W-1:0]  r_mul_a;
  logic [OP_W-1:0]  r_mul_b;
  logic [RES_W-1:0] r_rsp_result;

  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_accept;
  logic             w_done_q;
  logic             w_rsp_hs;
  logic             w_timeout;

  // Ready is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    w_rdy0   = (r_state == ST_IDLE) && reset && bus.req0_valid &&
               (!bus.req1_valid || !r_rr_ptr);
    w_rdy1   = (r_state == ST_IDLE) && reset && bus.req1_valid &&
               (!bus.req0_valid || r_rr_ptr);
    w_accept = w_rdy0 || w_rdy1;
    w_done_q = (r_state == ST_WAIT) && bus.mul_done && r_done_armed;
    w_rsp_hs = (r_state == ST_RESP) &&
               (r_grant_id ? bus.rsp1_ready : bus.rsp0_ready);
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_rsp_err;

  assign w_timeout = (r_state == ST_WAIT) && !w_done_q &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (r_state == ST_START) begin
        r_wait_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_rsp_err <= 1'b1;
      end else if (w_rsp_hs) begin
        r_rsp_err <= 1'b0;
      end
    end
  end

  assign bus.rsp_err = r_rsp_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = ST_START;
      ST_START: w_next_state = ST_WAIT;
      ST_WAIT:  if (w_done_q || w_timeout) w_next_state = ST_RESP;
      ST_RESP:  if (w_rsp_hs) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= 1'b0;
      r_grant_id   <= 1'b0;
      r_done_armed <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_grant_id <= w_rdy1;
      end
      if (w_rsp_hs) begin
        r_rr_ptr <= ~r_grant_id;
      end
      // A DONE still high from the previous operation only counts after it has been seen low.
      if (r_state == ST_START) begin
        r_done_armed <= 1'b0;
      end else if (r_state == ST_WAIT && !bus.mul_done) begin
        r_done_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_rsp_result <= '0;
    end else begin
      if (w_accept) begin
        r_mul_a <= w_rdy1 ? bus.req1_a : bus.req0_a;
        r_mul_b <= w_rdy1 ? bus.req1_b : bus.req0_b;
      end
      if (w_done_q) begin
        r_rsp_result <= bus.mul_result;
      end else if (w_timeout) begin
        r_rsp_result <= '0;
      end
    end
  end

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.rsp0_valid = (r_state == ST_RESP) && !r_grant_id;
  assign bus.rsp1_valid = (r_state == ST_RESP) && r_grant_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.mul_init   = (r_state == ST_START);
  assign bus.mul_a      = r_mul_a;
  assign bus.mul_b      = r_mul_b;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.grant_id   = r_grant_id;

endmodule
